// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer on the free-running reference clock.
// Holds the PLL in reset, waits for a stable lock, then releases sys_rst.
//
// Ports:
//   refclk      free-running reference clock (only clock)
//   rst         synchronous active-high reset
//   pll_locked  asynchronous PLL lock, synchronized internally
//   relock_req  single-cycle pulse forcing a full re-sequence
//   pll_rst     active-high reset to the PLL
//   sys_rst     active-high synchronous reset for PLL-clocked logic
//   ready       high only while running with a stable lock
//   fail        high only after the retry budget is exhausted
//   attempt     attempt index of the current sequence
//   lost_count  lock losses seen while running, saturating at 255
module pll_reset_sequencer #(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                             refclk,
    input  logic                             rst,
    input  logic                             pll_locked,
    input  logic                             relock_req,
    output logic                             pll_rst,
    output logic                             sys_rst,
    output logic                             ready,
    output logic                             fail,
    output logic [$clog2(MAX_RETRIES+2)-1:0] attempt,
    output logic [7:0]                       lost_count
);

    localparam int AW = $clog2(MAX_RETRIES + 2);
    localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);

    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] STB_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [AW-1:0] ATT_MAX   = AW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_RETRY,
        S_FAIL
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            sync_meta;
    logic            lk;
    logic [HW-1:0]   hold_q;
    logic [HW-1:0]   hold_d;
    logic [TW-1:0]   tmo_q;
    logic [TW-1:0]   tmo_d;
    logic [SW-1:0]   stb_q;
    logic [SW-1:0]   stb_d;
    logic [AW-1:0]   attempt_d;
    logic [7:0]      lost_d;
    logic            pll_rst_d;
    logic            sys_rst_d;
    logic            ready_d;
    logic            fail_d;
    logic            win_q;
    logic            win_d;

    // State register: FSM state, synchronizer, counters and the
    // outputs, which are registered from the next-state decode.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q    <= S_HOLD;
            sync_meta  <= 1'b0;
            lk         <= 1'b0;
            hold_q     <= '0;
            tmo_q      <= '0;
            stb_q      <= '0;
            attempt    <= '0;
            lost_count <= '0;
            pll_rst    <= 1'b1;
            sys_rst    <= 1'b1;
            ready      <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_meta  <= pll_locked;
            lk         <= sync_meta;
            hold_q     <= hold_d;
            tmo_q      <= tmo_d;
            stb_q      <= stb_d;
            attempt    <= attempt_d;
            lost_count <= lost_d;
            pll_rst    <= pll_rst_d;
            sys_rst    <= sys_rst_d;
            ready      <= ready_d;
            fail       <= fail_d;
        end
    end

    // Next state plus counter/attempt/loss bookkeeping.
    always_comb begin
        state_d   = state_q;
        attempt_d = attempt;
        lost_d    = lost_count;

        if (relock_req) begin
            state_d = S_HOLD;
            if (state_q != S_HOLD) begin
                attempt_d = '0;
            end
        end else begin
            unique case (state_q)
                S_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    if (tmo_q == TMO_LAST) begin
                        state_d = S_RETRY;
                    end else if (lk) begin
                        state_d = S_STABLE;
                    end
                end
                S_STABLE: begin
                    // Completing stability beats an expiring timeout.
                    if (lk && stb_q == STB_LAST) begin
                        state_d = S_RUN;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = S_RETRY;
                    end else if (!lk) begin
                        state_d = S_WAIT_LOCK;
                    end
                end
                S_RUN: begin
                    if (!lk) begin
                        state_d   = S_HOLD;
                        attempt_d = '0;
                        if (lost_count != 8'hff) begin
                            lost_d = lost_count + 8'd1;
                        end
                    end
                end
                S_RETRY: begin
                    if (attempt == ATT_MAX) begin
                        state_d = S_FAIL;
                    end else begin
                        state_d   = S_HOLD;
                        attempt_d = attempt + 1'b1;
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d = S_HOLD;
                end
            endcase
        end

        // The timeout spans WAIT_LOCK and STABLE together, so bouncing
        // between them keeps counting; any other path clears it.
        win_q = (state_q == S_WAIT_LOCK) || (state_q == S_STABLE);
        win_d = (state_d == S_WAIT_LOCK) || (state_d == S_STABLE);
        tmo_d = (win_q && win_d) ? tmo_q + 1'b1 : '0;

        hold_d = (state_q == S_HOLD && state_d == S_HOLD && !relock_req)
               ? hold_q + 1'b1 : '0;

        stb_d = (state_q == S_STABLE && state_d == S_STABLE)
              ? stb_q + 1'b1 : '0;
    end

    // Output decode from the next state.
    always_comb begin
        pll_rst_d = 1'b1;
        sys_rst_d = 1'b1;
        ready_d   = 1'b0;
        fail_d    = 1'b0;
        unique case (state_d)
            S_WAIT_LOCK, S_STABLE: begin
                pll_rst_d = 1'b0;
            end
            S_RUN: begin
                pll_rst_d = 1'b0;
                sys_rst_d = 1'b0;
                ready_d   = 1'b1;
            end
            S_FAIL: begin
                fail_d = 1'b1;
            end
            default: begin
                pll_rst_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer.
// Scenario tasks with a cycle-level behavioural reference model.
module tb_pll_reset_sequencer;

    localparam int H  = 4;
    localparam int T  = 20;
    localparam int S  = 5;
    localparam int MR = 2;
    localparam int AW = $clog2(MR + 2);

    localparam int P_HOLD   = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_RUN    = 3;
    localparam int P_RETRY  = 4;
    localparam int P_FAIL   = 5;

    logic          refclk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_locked = 1'b0;
    logic          relock_req = 1'b0;
    logic          pll_rst;
    logic          sys_rst;
    logic          ready;
    logic          fail;
    logic [AW-1:0] attempt;
    logic [7:0]    lost_count;
    logic [13:0]   obs;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model state.
    int m_ph = P_HOLD;
    int m_age = 0;
    int m_win = 0;
    int m_streak = 0;
    int m_att = 0;
    int m_lost = 0;
    bit m_s1 = 1'b0;
    bit m_lk = 1'b0;

    pll_reset_sequencer #(
        .RST_HOLD_CYCLES     (H),
        .LOCK_TIMEOUT_CYCLES (T),
        .LOCK_STABLE_CYCLES  (S),
        .MAX_RETRIES         (MR)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fail       (fail),
        .attempt    (attempt),
        .lost_count (lost_count)
    );

    always #5 refclk = ~refclk;

    assign obs = {pll_rst, sys_rst, ready, fail, attempt, lost_count};

    // One clock edge of the behavioural model.
    task automatic model_edge(input bit r, input bit l, input bit q);
        if (r) begin
            m_ph = P_HOLD; m_age = 0; m_win = 0; m_streak = 0;
            m_att = 0; m_lost = 0; m_s1 = 1'b0; m_lk = 1'b0;
        end else begin
            if (q) begin
                if (m_ph != P_HOLD) m_att = 0;
                m_ph = P_HOLD; m_age = 0;
            end else begin
                case (m_ph)
                    P_HOLD: begin
                        if (m_age == H - 1) begin
                            m_ph = P_WAIT; m_win = 0;
                        end else m_age++;
                    end
                    P_WAIT: begin
                        if (m_win == T - 1) m_ph = P_RETRY;
                        else begin
                            m_win++;
                            if (m_lk) begin
                                m_ph = P_STABLE; m_streak = 0;
                            end
                        end
                    end
                    P_STABLE: begin
                        if (m_lk && m_streak == S - 1) m_ph = P_RUN;
                        else if (m_win == T - 1) m_ph = P_RETRY;
                        else begin
                            m_win++;
                            if (m_lk) m_streak++;
                            else m_ph = P_WAIT;
                        end
                    end
                    P_RUN: begin
                        if (!m_lk) begin
                            m_att = 0;
                            if (m_lost < 255) m_lost++;
                            m_ph = P_HOLD; m_age = 0;
                        end
                    end
                    P_RETRY: begin
                        if (m_att == MR) m_ph = P_FAIL;
                        else begin
                            m_att++;
                            m_ph = P_HOLD; m_age = 0;
                        end
                    end
                    default: ;
                endcase
            end
            m_lk = m_s1;
            m_s1 = l;
        end
    endtask

    function automatic logic [13:0] exp_vec();
        logic pr;
        pr = (m_ph == P_HOLD) || (m_ph == P_RETRY) || (m_ph == P_FAIL);
        return {pr, m_ph != P_RUN, m_ph == P_RUN, m_ph == P_FAIL,
                AW'(m_att), 8'(m_lost)};
    endfunction

    task automatic tick(input bit r, input bit l, input bit q);
        rst = r;
        pll_locked = l;
        relock_req = q;
        @(posedge refclk);
        model_edge(r, l, q);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1);
            n_chk++;
            if ({pll_rst, sys_rst, ready, fail} !== 4'b1100
                || attempt !== '0 || lost_count !== 8'd0)
                $display("FAIL reset_vals i=%0d got %h want 1100/0/0", i, obs);
            else n_pass++;
            n_chk++;
            if (obs !== exp_vec())
                $display("FAIL reset_model i=%0d got %h want %h", i, obs, exp_vec());
            else n_pass++;
        end
        tick(1'b0, 1'b0, 1'b0);
        n_chk++;
        if (obs !== exp_vec() || pll_rst !== 1'b1)
            $display("FAIL reset_after got %h want %h", obs, exp_vec());
        else n_pass++;
    endtask

    task automatic test_clean_lock();
        int rdy_at;
        rdy_at = -1;
        tick(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            tick(1'b0, k >= 8, 1'b0);
            n_chk++;
            if (obs !== exp_vec())
                $display("FAIL clean k=%0d got %h want %h", k, obs, exp_vec());
            else n_pass++;
            if (ready && rdy_at < 0) rdy_at = k;
            if (k == 3 || k == 4) begin
                n_chk++;
                if (pll_rst !== (k == 3))
                    $display("FAIL clean_pll_rst k=%0d got %b want %b", k, pll_rst, k == 3);
                else n_pass++;
            end
        end
        // Lock sampled at edge 8, lk at 9, STABLE at 10, RUN 5 edges later.
        n_chk++;
        if (rdy_at !== 15 || attempt !== '0)
            $display("FAIL clean_ready got %0d/%0d want 15/0", rdy_at, attempt);
        else n_pass++;
    endtask

    // Three high, two low, then high. v=1 places the glitch late so the
    // unreset timeout forces a retry before stability can complete.
    task automatic test_glitch();
        int base;
        int rdy_at;
        int want;
        bit lv;
        for (int v = 0; v < 2; v++) begin
            base = (v == 0) ? 6 : 13;
            want = (v == 0) ? 18 : 35;
            rdy_at = -1;
            tick(1'b1, 1'b0, 1'b0);
            for (int k = 1; k <= 40; k++) begin
                lv = (k >= base && k < base + 3) || k >= base + 5;
                tick(1'b0, lv, 1'b0);
                n_chk++;
                if (obs !== exp_vec())
                    $display("FAIL glitch v%0d k=%0d got %h want %h", v, k, obs, exp_vec());
                else n_pass++;
                if (ready && rdy_at < 0) rdy_at = k;
                if (v == 1 && k == 25) begin
                    n_chk++;
                    if (attempt !== AW'(1))
                        $display("FAIL glitch_retry got %0d want 1", attempt);
                    else n_pass++;
                end
            end
            n_chk++;
            if (rdy_at !== want)
                $display("FAIL glitch_ready v%0d got %0d want %0d", v, rdy_at, want);
            else n_pass++;
        end
    endtask

    // Stability completing on the last timeout cycle (rise 17) wins;
    // one cycle later (rise 18) the attempt times out.
    task automatic test_timeout_boundary();
        int rise;
        int rdy_at;
        int want;
        for (int v = 0; v < 2; v++) begin
            rise = 17 + v;
            want = (v == 0) ? 24 : 35;
            rdy_at = -1;
            tick(1'b1, 1'b0, 1'b0);
            for (int k = 1; k <= 40; k++) begin
                tick(1'b0, k >= rise, 1'b0);
                n_chk++;
                if (obs !== exp_vec())
                    $display("FAIL tmo_edge v%0d k=%0d got %h want %h", v, k, obs, exp_vec());
                else n_pass++;
                if (ready && rdy_at < 0) rdy_at = k;
            end
            n_chk++;
            if (rdy_at !== want || attempt !== AW'(v))
                $display("FAIL tmo_edge_ready v%0d got %0d/%0d want %0d/%0d",
                         v, rdy_at, attempt, want, v);
            else n_pass++;
        end
    endtask

    task automatic test_timeout_fail();
        int held;
        held = 0;
        tick(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 200; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            n_chk++;
            if (obs !== exp_vec())
                $display("FAIL tmo k=%0d got %h want %h", k, obs, exp_vec());
            else n_pass++;
            if (k == 25 || k == 50) begin
                n_chk++;
                if (attempt !== AW'(k / 25))
                    $display("FAIL tmo_attempt k=%0d got %0d want %0d", k, attempt, k / 25);
                else n_pass++;
            end
            // RETRY cycle plus HOLD keeps pll_rst high for H+1 cycles.
            if (k == 28 || k == 29) begin
                n_chk++;
                if (pll_rst !== (k == 28))
                    $display("FAIL tmo_pulse k=%0d got %b want %b", k, pll_rst, k == 28);
                else n_pass++;
            end
            if (k == 74 || k == 75) begin
                n_chk++;
                if (fail !== (k == 75))
                    $display("FAIL tmo_fail k=%0d got %b want %b", k, fail, k == 75);
                else n_pass++;
            end
            if (k >= 75 && fail && pll_rst && sys_rst && !ready) held++;
        end
        n_chk++;
        if (held !== 126)
            $display("FAIL fail_held got %0d want 126", held);
        else n_pass++;
    endtask

    task automatic test_lock_loss();
        tick(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 45; k++) begin
            tick(1'b0, k != 15, 1'b0);
            n_chk++;
            if (obs !== exp_vec())
                $display("FAIL loss k=%0d got %h want %h", k, obs, exp_vec());
            else n_pass++;
            if (k == 17) begin
                n_chk++;
                if (sys_rst !== 1'b1 || pll_rst !== 1'b1
                    || lost_count !== 8'd1 || attempt !== '0)
                    $display("FAIL loss_hold got %h want sys/pll=1 lost=1 att=0", obs);
                else n_pass++;
            end
            if (k == 26 || k == 27) begin
                n_chk++;
                if (ready !== (k == 27))
                    $display("FAIL loss_rerun k=%0d got %b want %b", k, ready, k == 27);
                else n_pass++;
            end
        end
    endtask

    task automatic test_relock();
        tick(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 45; k++) begin
            tick(1'b0, k != 12, k == 26 || k == 28);
            n_chk++;
            if (obs !== exp_vec())
                $display("FAIL relock k=%0d got %h want %h", k, obs, exp_vec());
            else n_pass++;
            if (k == 26) begin
                n_chk++;
                if ({pll_rst, sys_rst, ready, fail} !== 4'b1100
                    || attempt !== '0 || lost_count !== 8'd1)
                    $display("FAIL relock_run got %h want 1100/0/1", obs);
                else n_pass++;
            end
            if (k == 31 || k == 32) begin
                n_chk++;
                if (pll_rst !== (k == 31))
                    $display("FAIL relock_hold k=%0d got %b want %b", k, pll_rst, k == 31);
                else n_pass++;
            end
        end
        tick(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 90; k++) begin
            tick(1'b0, 1'b0, k == 80);
            n_chk++;
            if (obs !== exp_vec())
                $display("FAIL relock_f k=%0d got %h want %h", k, obs, exp_vec());
            else n_pass++;
            if (k == 79 || k == 80) begin
                n_chk++;
                if (fail !== (k == 79) || pll_rst !== 1'b1
                    || attempt !== AW'((k == 79) ? 2 : 0))
                    $display("FAIL relock_fail k=%0d got %h", k, obs);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_stable();
        int rdy_at;
        rdy_at = -1;
        tick(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 25; k++) begin
            tick(k == 7, 1'b1, 1'b0);
            n_chk++;
            if (obs !== exp_vec())
                $display("FAIL midrst k=%0d got %h want %h", k, obs, exp_vec());
            else n_pass++;
            if (ready && rdy_at < 0) rdy_at = k;
            if (k == 7) begin
                n_chk++;
                if ({pll_rst, sys_rst, ready, fail} !== 4'b1100
                    || attempt !== '0 || lost_count !== 8'd0)
                    $display("FAIL midrst_vals got %h want 1100/0/0", obs);
                else n_pass++;
            end
        end
        n_chk++;
        if (rdy_at !== 17)
            $display("FAIL midrst_ready got %0d want 17", rdy_at);
        else n_pass++;
    endtask

    task automatic test_saturation();
        tick(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 5300; k++) begin
            tick(1'b0, !(k >= 19 && k % 20 == 19), 1'b0);
            n_chk++;
            if (obs !== exp_vec())
                $display("FAIL sat k=%0d got %h want %h", k, obs, exp_vec());
            else n_pass++;
        end
        n_chk++;
        if (lost_count !== 8'd255)
            $display("FAIL sat_final got %0d want 255", lost_count);
        else n_pass++;
    endtask

    task automatic test_random();
        bit lv;
        bit r;
        bit q;
        lv = 1'b0;
        tick(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 3000; k++) begin
            lv = lv ? ($urandom_range(29, 0) != 0) : ($urandom_range(7, 0) == 0);
            r = ($urandom_range(399, 0) == 0);
            q = ($urandom_range(119, 0) == 0);
            tick(r, lv, q);
            n_chk++;
            if (obs !== exp_vec())
                $display("FAIL rand k=%0d got %h want %h", k, obs, exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_glitch();
        test_timeout_boundary();
        test_timeout_fail();
        test_lock_loss();
        test_relock();
        test_reset_mid_stable();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Controls the PLL's reset and lock: holds the PLL in reset, then waits for lock, then requires lock to stay stable.
- Only after that does it release a synchronous system reset to the logic driven from the PLL output.
- Watches for loss of lock and re-sequences. Retries a bounded number of times on lock timeout, then flags a failure.
- Sits beside the 50 MHz→150 MHz PLL wrapper and runs on the free-running reference clock.

Parameters:
- RST_HOLD_CYCLES, 16: refclk cycles pll_rst is asserted per attempt (≥1).
- LOCK_TIMEOUT_CYCLES, 50000: cycles allowed in WAIT_LOCK+STABLE per attempt (1 ms at 50 MHz).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before release (≥1).
- MAX_RETRIES, 3: failed attempts after the first before entering FAIL.

Ports:
- refclk  in  1  free-running reference clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL locked output; asynchronous, synchronized internally.
- relock_req  in  1  single-cycle pulse requesting a full re-sequence.
- pll_rst  out  1  reset to the PLL, active-high.
- sys_rst  out  1  synchronous reset for downstream logic, active-high.
- ready  out  1  high only in RUN.
- fail  out  1  high only in FAIL.
- attempt  out  $clog2(MAX_RETRIES+2)  attempt index of the current sequence, starting at 0.
- lost_count  out  8  count of lock losses seen in RUN; saturates at 255.

Behaviour:
- Synchronizer:
  - pll_locked passes through a 2-flop synchronizer → lk.
  - All decisions use lk, so there are 2 cycles of input latency.
  - Synchronizer flops reset to 0.
- Reset values, while rst is high and on the first cycle after:
  - state = HOLD; pll_rst = 1; sys_rst = 1; ready = 0; fail = 0.
  - attempt = 0; lost_count = 0; all counters = 0.
- HOLD:
  - pll_rst = 1, sys_rst = 1.
  - Hold counter counts 0..RST_HOLD_CYCLES-1, then go to WAIT_LOCK.
  - The timeout counter is cleared on entry to WAIT_LOCK.
- WAIT_LOCK:
  - pll_rst = 0, sys_rst = 1.
  - Timeout counter increments every cycle.
  - lk = 1 → STABLE, with the stable counter cleared.
  - If the timeout counter reaches LOCK_TIMEOUT_CYCLES-1 first → RETRY.
- STABLE:
  - pll_rst = 0, sys_rst = 1.
  - Timeout counter keeps incrementing; stable counter increments while lk = 1.
  - lk = 0 → WAIT_LOCK; the timeout counter is not cleared.
  - Stable counter reaches LOCK_STABLE_CYCLES-1 with lk = 1 → RUN.
  - If timeout and stability complete in the same cycle, RUN wins.
- RUN:
  - pll_rst = 0, sys_rst = 0, ready = 1.
  - lk = 0 → HOLD; attempt is cleared to 0; lost_count increments, saturating at 255.
  - sys_rst is reasserted on the cycle after the transition, i.e. registered.
- RETRY (one cycle):
  - pll_rst = 1, sys_rst = 1.
  - attempt == MAX_RETRIES → FAIL.
  - Otherwise attempt += 1 → HOLD.
- FAIL:
  - pll_rst = 1, sys_rst = 1, fail = 1.
  - Stays in FAIL until rst or relock_req.
- relock_req:
  - In any state other than HOLD: → HOLD, attempt = 0, lost_count unchanged.
  - In HOLD: the hold counter restarts from 0.
  - relock_req has priority over all other transitions in the same cycle.
  - rst has priority over relock_req.
- Outputs:
  - All outputs are registered and decoded from the next state, so they change in the same cycle as the state register.
  - sys_rst is glitch-free and never deasserts outside RUN.
- Reset mid-operation: rst asserted in any state forces the reset values on the next edge. No partial counts carry over.

Test Plan (use parameters RST_HOLD_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=5, MAX_RETRIES=2):
- Clean lock: release rst; raise pll_locked at cycle 8 and hold it high.
  - Required: pll_rst high for cycles 1–4, low from cycle 5.
  - Required: sys_rst falls and ready rises exactly 2+5 cycles after pll_locked rises, plus the state-register cycle; attempt = 0.
- Glitchy lock: pll_locked high 3 cycles, low 2, then high.
  - Required: no RUN until 5 consecutive synchronized-high cycles.
  - Required: the timeout counter is not reset by the glitch.
- Timeout and failure: keep pll_locked at 0.
  - Required: attempt steps 0→1→2, with pll_rst pulsed 4 cycles each time.
  - Required: then FAIL with fail = 1, pll_rst = 1, sys_rst = 1, held for 100+ cycles.
- Lock loss in RUN: reach RUN, then drop pll_locked for 1 cycle.
  - Required: sys_rst = 1 within 3 cycles of the drop; lost_count = 1; HOLD re-entered with attempt = 0; RUN regained.
- relock_req in RUN and in FAIL:
  - Required: → HOLD the next cycle with attempt = 0; lost_count unchanged.
  - Required: a pulse during HOLD extends pll_rst to 4 cycles after the pulse.
- Reset mid-STABLE: assert rst for 1 cycle during STABLE.
  - Required: all outputs return to reset values, and the sequence restarts from HOLD with counters at 0.
